// File: rtl/snk_upload_pkg.sv
// ---------------------------------------------------------------------------
// snk_upload_pkg
// Shared definitions for the ioctl save-RAM upload server:
//   upl_state_t    : read-server state machine encoding
//   UPL_INDEX_DEF  : default ioctl_index served by the upload block
//   OOR_FILL       : byte returned for addresses beyond the save RAM
// ---------------------------------------------------------------------------
package snk_upload_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      READ = 2'd2,
      CAPT = 2'd3
   } upl_state_t;

   localparam logic [7:0] UPL_INDEX_DEF = 8'd4;
   localparam logic [7:0] OOR_FILL      = 8'hFF;

endpackage

// File: rtl/upl_quiet_timer.sv
// ---------------------------------------------------------------------------
// upl_quiet_timer
// Autosave quiet-period timer. Every kick reloads the counter to QUIET_CYC.
// The counter then decrements once per cycle until it reaches zero.
// Only instantiated when SNK_UPLOAD_AUTOSAVE_EN is defined.
//
// Ports
//   i_clk    in   system clock
//   RESETn   in   asynchronous active-low reset
//   kick     in   reload the counter (a write to the save RAM happened)
//   clear    in   drop the counter to zero (upload has started)
//   expired  out  the counter reaches zero at the next edge, or is already
//                 zero, and no kick is pending this cycle
// ---------------------------------------------------------------------------
module upl_quiet_timer #(
   parameter logic [23:0] QUIET_CYC = 24'd5_360_000
) (
   input  logic i_clk,
   input  logic RESETn,
   input  logic kick,
   input  logic clear,
   output logic expired
);

   logic [23:0] cnt_q;

   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         cnt_q <= '0;
      end else if (kick) begin
         cnt_q <= QUIET_CYC;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 24'd1;
      end
   end

   // Flagged one cycle early (count of 1) so the request register rises on
   // the same edge on which the count reaches zero.
   assign expired = !kick && (cnt_q <= 24'd1);

endmodule

// File: rtl/ioctl_upload_server.sv
// ---------------------------------------------------------------------------
// ioctl_upload_server
// Serves HPS ioctl upload byte requests for index UPL_INDEX from the core's
// save RAM, arbitrating with the core for the RAM read port. Raises
// ioctl_upload_req on an explicit save request and, when the macro
// SNK_UPLOAD_AUTOSAVE_EN is defined, after a quiet period following core
// writes to the save RAM.
//
// Ports
//   i_clk             in   system clock (53.6 MHz)
//   RESETn            in   asynchronous active-low reset
//   ioctl_upload      in   HPS upload in progress
//   ioctl_rd          in   HPS byte request (one-cycle pulse)
//   ioctl_index       in   current transfer index
//   ioctl_addr        in   byte address requested by the HPS
//   ioctl_din         out  byte returned to the HPS (held between requests)
//   ioctl_wait        out  stalls the HPS until ioctl_din is valid
//   ioctl_upload_req  out  asks the HPS to start an upload
//   save_req          in   explicit save request (one-cycle pulse)
//   core_busy         in   core owns the RAM port this cycle
//   core_wr           in   core write strobe into the save RAM (snooped)
//   mem_addr          out  save RAM read address
//   mem_rd            out  save RAM read strobe
//   mem_q             in   save RAM data, valid one cycle after mem_rd
//   saving            out  a matching upload is active
//
// Configuration
//   SNK_UPLOAD_AUTOSAVE_EN  enables dirty tracking and the quiet timer
// ---------------------------------------------------------------------------
module ioctl_upload_server
   import snk_upload_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter logic [7:0]  UPL_INDEX = UPL_INDEX_DEF,
   parameter logic [23:0] QUIET_CYC = 24'd5_360_000
) (
   input  logic              i_clk,
   input  logic              RESETn,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [7:0]        ioctl_index,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic              ioctl_upload_req,
   input  logic              save_req,
   input  logic              core_busy,
   input  logic              core_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_q,
   output logic              saving
);

   upl_state_t        state_q, state_d;
   logic [24:0]       addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic              wait_q, wait_d;
   logic              mem_rd_q, mem_rd_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              req_q, req_d;
   logic              saving_q;

   logic idx_match;
   logic rd_hit;
   logic addr_oor;
   logic autosave_fire;

   assign idx_match = ioctl_upload && (ioctl_index == UPL_INDEX);
   assign rd_hit    = ioctl_rd && idx_match;
   // Any address bit above the RAM width set means the byte does not exist.
   assign addr_oor  = |addr_q[24:ADDR_W];

   // ------------------------------------------------------------------------
   // Autosave: dirty flag plus quiet timer
   // ------------------------------------------------------------------------
`ifdef SNK_UPLOAD_AUTOSAVE_EN
   logic upload_start;
   logic dirty_q;
   logic quiet_expired;

   assign upload_start = idx_match && !saving_q;

   upl_quiet_timer #(
      .QUIET_CYC (QUIET_CYC)
   ) u_quiet_timer (
      .i_clk   (i_clk),
      .RESETn  (RESETn),
      .kick    (core_wr),
      .clear   (upload_start),
      .expired (quiet_expired)
   );

   // A write during an upload re-dirties the RAM so another save follows.
   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         dirty_q <= 1'b0;
      end else if (core_wr) begin
         dirty_q <= 1'b1;
      end else if (upload_start) begin
         dirty_q <= 1'b0;
      end
   end

   // Level-sensitive so a save that fell due during an upload is raised
   // again once that upload ends.
   assign autosave_fire = quiet_expired && dirty_q;
`else
   logic unused_core_wr;

   assign unused_core_wr = core_wr;
   assign autosave_fire  = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Upload request: set by save/autosave, cleared once a matching upload
   // is seen (clear wins so a request never outlives the upload it asked for)
   // ------------------------------------------------------------------------
   always_comb begin
      req_d = req_q;
      if (save_req || autosave_fire) begin
         req_d = 1'b1;
      end
      if (idx_match) begin
         req_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Read server state machine
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         din_q      <= '0;
         wait_q     <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         req_q      <= 1'b0;
         saving_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         wait_q     <= wait_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         req_q      <= req_d;
         saving_q   <= idx_match;
      end
   end

   // mem_rd/mem_addr are registered on the ARB->READ edge, so the strobe is
   // high during READ and mem_q is valid during CAPT. The request address is
   // latched in IDLE so the whole transaction uses one address.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      din_d      = din_q;
      wait_d     = wait_q;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;

      if (!ioctl_upload) begin
         state_d = IDLE;
         wait_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rd_hit) begin
                  state_d = ARB;
                  wait_d  = 1'b1;
                  addr_d  = ioctl_addr;
               end
            end
            ARB: begin
               if (addr_oor) begin
                  din_d   = OOR_FILL;
                  wait_d  = 1'b0;
                  state_d = IDLE;
               end else if (!core_busy) begin
                  mem_addr_d = addr_q[ADDR_W-1:0];
                  mem_rd_d   = 1'b1;
                  state_d    = READ;
               end
            end
            READ: begin
               state_d = CAPT;
            end
            CAPT: begin
               din_d   = mem_q;
               wait_d  = 1'b0;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign ioctl_din        = din_q;
   assign ioctl_wait       = wait_q;
   assign ioctl_upload_req = req_q;
   assign mem_addr         = mem_addr_q;
   assign mem_rd           = mem_rd_q;
   assign saving           = saving_q;

endmodule

// File: doc/ioctl_upload_server.md
IOCTL_UPLOAD_SERVER -- requirements
Module: ioctl_upload_server

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset. All other ports SHALL be synchronous to i_clk.
REQ-002 Parameter ADDR_W, default 10: width of the core-side save RAM address.
REQ-003 Parameter UPL_INDEX, default 8'd4: the ioctl_index value this block serves.
REQ-004 Parameter QUIET_CYC, default 24'd5_360_000: autosave quiet period, in cycles (about 100 ms at 53.6 MHz).
REQ-005 i_clk  in  1  system clock, 53.6 MHz.
REQ-006 RESETn  in  1  asynchronous active-low reset.
REQ-007 ioctl_upload  in  1  HPS upload in progress.
REQ-008 ioctl_rd  in  1  HPS byte request, one-cycle pulse.
REQ-009 ioctl_index  in  8  current transfer index.
REQ-010 ioctl_addr  in  25  byte address requested by the HPS.
REQ-011 ioctl_din  out  8  byte returned to the HPS.
REQ-012 ioctl_wait  out  1  stalls the HPS until ioctl_din is valid.
REQ-013 ioctl_upload_req  out  1  asks the HPS to start an upload.
REQ-014 save_req  in  1  explicit save request, one-cycle pulse.
REQ-015 core_busy  in  1  core owns the RAM port this cycle.
REQ-016 core_wr  in  1  core write strobe into the save RAM (snoop only).
REQ-017 mem_addr  out  ADDR_W  save RAM read address.
REQ-018 mem_rd  out  1  save RAM read strobe.
REQ-019 mem_q  in  8  save RAM data, valid 1 cycle after mem_rd.
REQ-020 saving  out  1  high while an upload with a matching index is active.

Function
REQ-021 Upload request:
- save_req SHALL set ioctl_upload_req.
- It SHALL clear on the first cycle where ioctl_upload=1 and ioctl_index==UPL_INDEX.
- A save_req while ioctl_upload_req is already set SHALL have no effect.
REQ-022 State machine states SHALL be IDLE, ARB, READ and CAPT.
REQ-023 IDLE->ARB SHALL occur on ioctl_rd=1 while ioctl_upload=1 and ioctl_index==UPL_INDEX. ioctl_wait SHALL be registered high from the next cycle.
REQ-024 ARB:
- The block SHALL stay in ARB while core_busy=1.
- Otherwise it SHALL drive mem_addr=ioctl_addr[ADDR_W-1:0], pulse mem_rd for one cycle, and go to READ.
REQ-025 READ->CAPT SHALL take one cycle, covering the RAM latency.
REQ-026 CAPT SHALL register ioctl_din<=mem_q, drop ioctl_wait and return to IDLE.
REQ-027 Latency: with ioctl_rd at cycle T and core_busy low, ioctl_din SHALL be valid and ioctl_wait low at T+4. Each core_busy cycle SHALL add one cycle.
REQ-028 If ioctl_addr >= 2**ADDR_W, the block SHALL return 8'hFF with no mem_rd, with ioctl_wait low at T+2.
REQ-029 ioctl_rd outside IDLE SHALL be ignored.
REQ-030 An ioctl_rd with a non-matching index SHALL be ignored, and ioctl_wait SHALL stay low.
REQ-031 If ioctl_upload falls in any state, the block SHALL go to IDLE the next cycle with ioctl_wait=0 and mem_rd=0. ioctl_din SHALL be held.
REQ-032 ioctl_din SHALL hold its last value between requests.

Reset
REQ-033 On RESETn=0, all outputs SHALL be forced to 0 immediately: ioctl_din=8'h00, ioctl_wait, ioctl_upload_req, mem_rd, mem_addr and saving.
REQ-034 On RESETn=0, the state SHALL go to IDLE and the autosave dirty flag and counter SHALL clear.
REQ-035 Reset mid-read SHALL abandon the read with no further mem_rd.

Configuration
REQ-036 Macro SNK_UPLOAD_AUTOSAVE_EN defined:
- core_wr SHALL set a dirty flag and reload the quiet counter to QUIET_CYC.
- The counter SHALL decrement every cycle while nonzero.
- When it reaches 0 with dirty=1, ioctl_upload_req SHALL be set.
- dirty SHALL clear when the upload starts.
- A core_wr during an upload SHALL set dirty again.
REQ-037 Macro undefined: the dirty and counter logic SHALL be absent, ioctl_upload_req SHALL be set only by save_req, and core_wr SHALL be unused.

Structure
REQ-038 Package snk_upload_pkg SHALL hold the state enum, the UPL_INDEX default and the 8'hFF out-of-range fill constant.
REQ-039 Under the macro, the quiet counter SHALL be sub-module upl_quiet_timer, with inputs kick and clear and output expired. With the macro undefined, the block SHALL have no sub-module.

Verification
REQ-040 The bench SHALL cover the scenarios below.
- save_req pulse, then ioctl_upload=1 and index 4 three cycles later -> ioctl_upload_req high for 3 cycles, then low; saving=1.
- ioctl_rd with addr 0x005, mem_q=8'hA5, core_busy=0 -> one mem_rd with mem_addr=0x005; ioctl_din=8'hA5 and ioctl_wait low at T+4.
- Same request with core_busy high for 3 cycles -> mem_rd delayed 3 cycles; ioctl_wait low at T+7.
- ioctl_rd with addr 0x400 (ADDR_W=10) -> no mem_rd; ioctl_din=8'hFF at T+2.
- ioctl_upload dropped while in READ -> IDLE next cycle, ioctl_wait=0. RESETn pulse during ARB -> all outputs 0 at once.
- SNK_UPLOAD_AUTOSAVE_EN with QUIET_CYC=16: core_wr, then 16 idle cycles -> ioctl_upload_req rises. core_wr at cycle 10 -> rise delayed to 16 cycles after that write. Macro off -> ioctl_upload_req never rises.
